// File: rtl/uart_pkg.sv
// Shared UART definitions for the transmit and receive paths.
//   CLK_FREQ / BAUD_RATE : system clock and line rate
//   CLKS_PER_BIT         : clock cycles per UART bit time (868 at 100 MHz / 115200)
//   BYTE_W               : payload width of one frame
//   tx_state_e           : serializer states
package uart_pkg;

  localparam int CLK_FREQ     = 100000000;
  localparam int BAUD_RATE    = 115200;
  localparam int CLKS_PER_BIT = CLK_FREQ / BAUD_RATE;
  localparam int BYTE_W       = 8;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_buffered_if.sv
// Byte producer -> UART transmitter handshake.
//   in_valid : producer presents in_byte (held until accepted)
//   in_byte  : byte to transmit
//   in_ready : transmitter can accept this cycle
// A byte moves on a clock edge where in_valid && in_ready.
interface uart_tx_buffered_if;
  import uart_pkg::*;

  logic              in_valid;
  logic [BYTE_W-1:0] in_byte;
  logic              in_ready;

  modport master (output in_valid, output in_byte, input in_ready);
  modport slave  (input in_valid, input in_byte, output in_ready);

endinterface

// File: rtl/uart_tx_buffered_sync_fifo.sv
// Single-clock FIFO with registered occupancy count.
//   clk, rst_n : clock, async active-low reset (pointers/count cleared)
//   push/wdata : write; ignored while full
//   pop/rdata  : rdata is the current head (combinational); pop advances it,
//                ignored while empty
//   full/empty : derived from the registered count
//   count      : entries held, AW+1 bits so full and empty are distinct
// DEPTH must be a power of two so the pointers wrap naturally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             do_push, do_pop;

  assign full    = (count_q == (AW+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rdata   = mem[rd_ptr_q];
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
    // simultaneous push and pop leaves the count unchanged
    if (do_push && !do_pop)      count_d = count_q + (AW+1)'(1);
    else if (!do_push && do_pop) count_d = count_q - (AW+1)'(1);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // storage carries no reset; stale entries are unreachable once pointers clear
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/uart_tx_buffered.sv
// Buffered 8N1 UART transmitter, LSB first.
//   clk, rst_n  : clock, async active-low reset (line forced high, FIFO flushed)
//   in_if       : valid/ready byte input (slave side), in_ready = FIFO not full
//   tx_serial   : UART line, idle high, registered
//   tx_active   : high from first start-bit cycle to last stop-bit cycle
//   tx_done     : one-cycle pulse during the final cycle of each stop bit
//   fifo_count  : bytes queued and not yet popped
// Queued bytes are sent back to back: the last stop-bit edge pops the next byte
// and starts its frame with no idle bit time in between.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = uart_pkg::CLKS_PER_BIT,
  parameter int FIFO_DEPTH   = 16,
  parameter int ADDR_W       = $clog2(FIFO_DEPTH)
) (
  input  logic                clk,
  input  logic                rst_n,
  uart_tx_buffered_if.slave   in_if,
  output logic                tx_serial,
  output logic                tx_active,
  output logic                tx_done,
  output logic [ADDR_W:0]     fifo_count
);
  import uart_pkg::*;

  localparam int BC_W = $clog2(CLKS_PER_BIT);

  localparam logic [1:0] IDLE  = TX_IDLE;
  localparam logic [1:0] START = TX_START;
  localparam logic [1:0] DATA  = TX_DATA;
  localparam logic [1:0] STOP  = TX_STOP;

  localparam logic [BC_W-1:0] BIT_LAST = BC_W'(CLKS_PER_BIT - 1);
  // tx_done is registered, so it is set one cycle early to land on the last stop cycle
  localparam logic [BC_W-1:0] DONE_AT  = BC_W'(CLKS_PER_BIT - 2);

  logic [1:0]        state_q, state_d;
  logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [2:0]        idx_q, idx_d;
  logic [BYTE_W-1:0] shift_q, shift_d;
  logic              tx_serial_q, tx_serial_d;
  logic              tx_active_q, tx_active_d;
  logic              tx_done_q, tx_done_d;

  logic              pop;
  logic              bit_end;
  logic [BYTE_W-1:0] fifo_rdata;
  logic              fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (BYTE_W),
    .DEPTH (FIFO_DEPTH),
    .AW    (ADDR_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (in_if.in_valid),
    .wdata (in_if.in_byte),
    .pop   (pop),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  // registered count only: a pop on a full FIFO does not open a slot that edge
  assign in_if.in_ready = !fifo_full;
  assign tx_serial      = tx_serial_q;
  assign tx_active      = tx_active_q;
  assign tx_done        = tx_done_q;
  assign bit_end        = (bit_cnt_q == BIT_LAST);

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    idx_d       = idx_q;
    shift_d     = shift_q;
    tx_serial_d = tx_serial_q;
    tx_active_d = tx_active_q;
    tx_done_d   = 1'b0;
    pop         = 1'b0;

    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          pop         = 1'b1;
          shift_d     = fifo_rdata;
          tx_serial_d = 1'b0;
          tx_active_d = 1'b1;
          bit_cnt_d   = '0;
          state_d     = START;
        end
      end

      START: begin
        if (bit_end) begin
          bit_cnt_d   = '0;
          idx_d       = '0;
          tx_serial_d = shift_q[0];
          state_d     = DATA;
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      DATA: begin
        if (bit_end) begin
          bit_cnt_d = '0;
          if (idx_q == 3'd7) begin
            tx_serial_d = 1'b1;
            state_d     = STOP;
          end else begin
            idx_d       = idx_q + 3'd1;
            shift_d     = shift_q >> 1;
            tx_serial_d = shift_q[1];
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      STOP: begin
        tx_done_d = (bit_cnt_q == DONE_AT);
        if (bit_end) begin
          bit_cnt_d = '0;
          if (!fifo_empty) begin
            // chain straight into the next start bit
            pop         = 1'b1;
            shift_d     = fifo_rdata;
            tx_serial_d = 1'b0;
            state_d     = START;
          end else begin
            tx_active_d = 1'b0;
            state_d     = IDLE;
          end
        end else begin
          bit_cnt_d = bit_cnt_q + BC_W'(1);
        end
      end

      default: begin
        tx_serial_d = 1'b1;
        tx_active_d = 1'b0;
        state_d     = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      bit_cnt_q   <= '0;
      idx_q       <= '0;
      shift_q     <= '0;
      tx_serial_q <= 1'b1;
      tx_active_q <= 1'b0;
      tx_done_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      idx_q       <= idx_d;
      shift_q     <= shift_d;
      tx_serial_q <= tx_serial_d;
      tx_active_q <= tx_active_d;
      tx_done_q   <= tx_done_d;
    end
  end

endmodule
